// File: rtl/mem_exec_unit.sv
// mem_exec_unit: single-op memory stage between the LSQ and the data cache.
// Build option MEM_MISALIGN_EXC_EN: trap misaligned H/W ops instead of issuing them.
package mem_exec_pkg;
    localparam int CPU_DATA_BITS = 32;
    localparam int TAG_BITS      = 6;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [CPU_DATA_BITS-1:0] data;
    } src_t;

    typedef struct packed {
        logic                is_valid;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [TAG_BITS-1:0] dest_tag;
        src_t                src_0_a;
        src_t                src_1_a;
    } instruction_t;

    typedef struct packed {
        logic                     is_valid;
        logic [TAG_BITS-1:0]      dest_tag;
        logic [CPU_DATA_BITS-1:0] result;
        logic                     exception;
    } writeback_packet_t;
endpackage

module mem_exec_unit
    import mem_exec_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  instruction_t             execute_pkt,
    output logic                     alu_rdy,
    output logic                     cache_stall,
    output logic                     dcache_req_valid,
    input  logic                     dcache_req_rdy,
    output logic                     dcache_req_we,
    output logic [ADDR_BITS-1:0]     dcache_req_addr,
    output logic [CPU_DATA_BITS-1:0] dcache_req_wdata,
    output logic [3:0]               dcache_req_wmask,
    input  logic                     dcache_resp_valid,
    input  logic [CPU_DATA_BITS-1:0] dcache_resp_data,
    output writeback_packet_t        cdb_out,
    input  logic                     cdb_grant,
    output logic [1:0]               dbg_state
);

    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [DW-1:0] DRAIN_SAT = DW'(DRAIN_MAX);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_WB = 2'd3} state_t;

    state_t                   state_q, state_d;
    logic                     we_q, we_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [CPU_DATA_BITS-1:0] wdata_q, wdata_d;
    logic [3:0]               wmask_q, wmask_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [1:0]               off_q, off_d;
    logic [TAG_BITS-1:0]      tag_q, tag_d;
    writeback_packet_t        cdb_q, cdb_d;
    logic [DW-1:0]            drain_q, drain_d;

    logic [ADDR_BITS-1:0]     in_addr;
    logic [1:0]               in_off;
    logic                     in_misalign;
    logic [CPU_DATA_BITS-1:0] in_wdata;
    logic [3:0]               in_wmask;
    logic [CPU_DATA_BITS-1:0] resp_shifted;
    logic [CPU_DATA_BITS-1:0] load_val;
    logic                     drain_inc;

    assign in_addr = execute_pkt.src_0_a.data[ADDR_BITS-1:0];

    // Lane offset, misalign check and store lane replication for the incoming op.
    always_comb begin
        in_misalign = 1'b0;
        in_off      = in_addr[1:0];
        in_wdata    = execute_pkt.src_1_a.data;
        in_wmask    = 4'b1111;
`ifdef MEM_MISALIGN_EXC_EN
        case (execute_pkt.funct3[1:0])
            2'b01:   in_misalign = in_addr[0];
            2'b10:   in_misalign = (in_addr[1:0] != 2'b00);
            default: in_misalign = 1'b0;
        endcase
`else
        case (execute_pkt.funct3[1:0])
            2'b01:   in_off = {in_addr[1], 1'b0};
            2'b10:   in_off = 2'b00;
            default: in_off = in_addr[1:0];
        endcase
`endif
        case (execute_pkt.funct3[1:0])
            2'b00: begin
                in_wdata = {4{execute_pkt.src_1_a.data[7:0]}};
                in_wmask = 4'b0001 << in_off;
            end
            2'b01: begin
                in_wdata = {2{execute_pkt.src_1_a.data[15:0]}};
                in_wmask = 4'b0011 << in_off;
            end
            default: ;
        endcase
    end

    assign resp_shifted = dcache_resp_data >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_val = {{(CPU_DATA_BITS-8){resp_shifted[7]}}, resp_shifted[7:0]};
            3'b001:  load_val = {{(CPU_DATA_BITS-16){resp_shifted[15]}}, resp_shifted[15:0]};
            3'b100:  load_val = {{(CPU_DATA_BITS-8){1'b0}}, resp_shifted[7:0]};
            3'b101:  load_val = {{(CPU_DATA_BITS-16){1'b0}}, resp_shifted[15:0]};
            default: load_val = resp_shifted;
        endcase
    end

    // execute_pkt/alu_rdy: an op transfers in any cycle where alu_rdy && execute_pkt.is_valid;
    // dcache_req: fields stay stable while dcache_req_valid is high until dcache_req_rdy.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        tag_d     = tag_q;
        cdb_d     = cdb_q;
        drain_d   = drain_q;
        drain_inc = 1'b0;
        alu_rdy   = (state_q == S_IDLE) && (drain_q == '0) && !flush;

        if (dcache_resp_valid && (drain_q != '0)) begin
            drain_d = drain_q - DW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (alu_rdy && execute_pkt.is_valid) begin
                    we_d     = (execute_pkt.opcode == OPC_STORE);
                    addr_d   = {in_addr[ADDR_BITS-1:2], 2'b00};
                    wdata_d  = (execute_pkt.opcode == OPC_STORE) ? in_wdata : '0;
                    wmask_d  = (execute_pkt.opcode == OPC_STORE) ? in_wmask : 4'b0000;
                    funct3_d = execute_pkt.funct3;
                    off_d    = in_off;
                    tag_d    = execute_pkt.dest_tag;
                    if (in_misalign) begin
                        cdb_d.is_valid  = 1'b1;
                        cdb_d.dest_tag  = execute_pkt.dest_tag;
                        cdb_d.result    = '0;
                        cdb_d.exception = 1'b1;
                        state_d         = S_WB;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d   = S_IDLE;
                    drain_inc = dcache_req_rdy && !we_q;
                end else if (dcache_req_rdy) begin
                    if (we_q) begin
                        cdb_d.is_valid  = 1'b1;
                        cdb_d.dest_tag  = tag_q;
                        cdb_d.result    = '0;
                        cdb_d.exception = 1'b0;
                        state_d         = S_WB;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A response arriving with the flush is simply dropped; nothing is owed.
                    state_d   = S_IDLE;
                    drain_inc = !dcache_resp_valid;
                end else if (dcache_resp_valid) begin
                    cdb_d.is_valid  = 1'b1;
                    cdb_d.dest_tag  = tag_q;
                    cdb_d.result    = load_val;
                    cdb_d.exception = 1'b0;
                    state_d         = S_WB;
                end
            end
            S_WB: begin
                if (flush || cdb_grant) begin
                    cdb_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drain_inc && (drain_q != DRAIN_SAT)) begin
            drain_d = drain_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= 4'b0000;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            tag_q    <= '0;
            cdb_q    <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            tag_q    <= tag_d;
            cdb_q    <= cdb_d;
            drain_q  <= drain_d;
        end
    end

    assign cache_stall      = (state_q != S_IDLE);
    assign dcache_req_valid = (state_q == S_REQ);
    assign dcache_req_we    = we_q;
    assign dcache_req_addr  = addr_q;
    assign dcache_req_wdata = wdata_q;
    assign dcache_req_wmask = wmask_q;
    assign cdb_out          = cdb_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed bench for mem_exec_unit: loads, stores, stalls, flush/drain, reset and misalignment.
module tb_mem_exec_unit;
    import mem_exec_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    instruction_t      execute_pkt;
    logic              alu_rdy, cache_stall, dcache_req_valid, dcache_req_we;
    logic              dcache_req_rdy = 1'b0;
    logic [31:0]       dcache_req_addr, dcache_req_wdata;
    logic [3:0]        dcache_req_wmask;
    logic              dcache_resp_valid = 1'b0;
    logic [31:0]       dcache_resp_data = '0;
    writeback_packet_t cdb_out;
    logic              cdb_grant = 1'b0;
    logic [1:0]        dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_exec_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .execute_pkt(execute_pkt),
        .alu_rdy(alu_rdy), .cache_stall(cache_stall),
        .dcache_req_valid(dcache_req_valid), .dcache_req_rdy(dcache_req_rdy),
        .dcache_req_we(dcache_req_we), .dcache_req_addr(dcache_req_addr),
        .dcache_req_wdata(dcache_req_wdata), .dcache_req_wmask(dcache_req_wmask),
        .dcache_resp_valid(dcache_resp_valid), .dcache_resp_data(dcache_resp_data),
        .cdb_out(cdb_out), .cdb_grant(cdb_grant), .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single cycle; returns one cycle after the transfer edge.
    task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic [5:0] tag,
                            input logic [31:0] addr, input logic [31:0] data);
        execute_pkt              = '0;
        execute_pkt.is_valid     = 1'b1;
        execute_pkt.opcode       = opc;
        execute_pkt.funct3       = f3;
        execute_pkt.dest_tag     = tag;
        execute_pkt.src_0_a.data = addr;
        execute_pkt.src_1_a.data = data;
        tick();
        execute_pkt.is_valid = 1'b0;
    endtask

    task automatic grant_cycle();
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
    endtask

    task automatic test_reset();
        execute_pkt = '0;
        #2 rst = 1'b0;
        #3;
        tests_run++; if (alu_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_alu_rdy: got %b want 1", alu_rdy); end
        tests_run++; if (cache_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_cache_stall: got %b want 0", cache_stall); end
        tests_run++; if ({dcache_req_valid, dcache_req_we, dcache_req_addr, dcache_req_wdata, dcache_req_wmask} !== '0) begin
            tests_failed++; $display("FAIL reset_req_fields: v=%b we=%b a=%h d=%h m=%b want all 0",
                dcache_req_valid, dcache_req_we, dcache_req_addr, dcache_req_wdata, dcache_req_wmask); end
        tests_run++; if (cdb_out !== '0) begin tests_failed++; $display("FAIL reset_cdb_out: got %h want 0", cdb_out); end
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        writeback_packet_t exp_wb;
        dcache_req_rdy = 1'b1;
        drive_op(OPC_LOAD, 3'b010, 6'd8, 32'h100, 32'h0);
        tests_run++; if (dcache_req_valid !== 1'b1 || dcache_req_addr !== 32'h100 || dcache_req_we !== 1'b0) begin
            tests_failed++; $display("FAIL lw_request: v=%b a=%h we=%b want 1/00000100/0", dcache_req_valid, dcache_req_addr, dcache_req_we); end
        tests_run++; if (cache_stall !== 1'b1) begin tests_failed++; $display("FAIL lw_stall_t1: got %b want 1", cache_stall); end
        tick();
        dcache_resp_valid = 1'b1;
        dcache_resp_data  = 32'hDEADBEEF;
        tests_run++; if (cdb_out.is_valid !== 1'b0) begin tests_failed++; $display("FAIL lw_cdb_early: got %b want 0", cdb_out.is_valid); end
        tick();
        dcache_resp_valid = 1'b0;
        exp_wb = '{is_valid: 1'b1, dest_tag: 6'd8, result: 32'hDEADBEEF, exception: 1'b0};
        tests_run++; if (cdb_out !== exp_wb) begin tests_failed++; $display("FAIL lw_cdb_t3: got %h want %h", cdb_out, exp_wb); end
        tick();
        tick();
        tests_run++; if (cdb_out !== exp_wb || cache_stall !== 1'b1) begin
            tests_failed++; $display("FAIL lw_cdb_hold: got %h stall=%b want %h stall=1", cdb_out, cache_stall, exp_wb); end
        grant_cycle();
        tests_run++; if (cdb_out.is_valid !== 1'b0 || alu_rdy !== 1'b1 || cache_stall !== 1'b0) begin
            tests_failed++; $display("FAIL lw_after_grant: valid=%b rdy=%b stall=%b want 0/1/0", cdb_out.is_valid, alu_rdy, cache_stall); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_tab[5]   = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] addr_tab[5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102};
        logic [31:0] exp_val;
        exp_q.push_back(32'hFFFFFF80);
        exp_q.push_back(32'h00000080);
        exp_q.push_back(32'h000080FF);
        exp_q.push_back(32'hFFFF80FF);
        exp_q.push_back(32'hFFFFFFFF);
        dcache_req_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_op(OPC_LOAD, f3_tab[i], 6'(i + 1), addr_tab[i], 32'h0);
            tick();
            dcache_resp_valid = 1'b1;
            dcache_resp_data  = 32'h80FF0000;
            tick();
            dcache_resp_valid = 1'b0;
            exp_val = exp_q.pop_front();
            tests_run++; if (cdb_out.is_valid !== 1'b1 || cdb_out.result !== exp_val || cdb_out.dest_tag !== 6'(i + 1)) begin
                tests_failed++; $display("FAIL load_ext_%0d: valid=%b result=%h tag=%0d want 1/%h/%0d",
                    i, cdb_out.is_valid, cdb_out.result, cdb_out.dest_tag, exp_val, i + 1); end
            grant_cycle();
        end
    endtask

    task automatic test_store_stall();
        writeback_packet_t exp_wb;
        dcache_req_rdy = 1'b0;
        drive_op(OPC_STORE, 3'b000, 6'd3, 32'h101, 32'h123456AB);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (dcache_req_valid !== 1'b1 || dcache_req_addr !== 32'h100 || dcache_req_we !== 1'b1 ||
                             dcache_req_wdata !== 32'hABABABAB || dcache_req_wmask !== 4'b0010) begin
                tests_failed++; $display("FAIL sb_held_%0d: v=%b a=%h we=%b d=%h m=%b want 1/00000100/1/abababab/0010",
                    i, dcache_req_valid, dcache_req_addr, dcache_req_we, dcache_req_wdata, dcache_req_wmask); end
            tick();
        end
        dcache_req_rdy = 1'b1;
        tick();
        exp_wb = '{is_valid: 1'b1, dest_tag: 6'd3, result: 32'h0, exception: 1'b0};
        tests_run++; if (cdb_out !== exp_wb) begin tests_failed++; $display("FAIL sb_wb: got %h want %h", cdb_out, exp_wb); end
        grant_cycle();
        // SH to upper half: minimum store latency, cdb valid two cycles after transfer.
        drive_op(OPC_STORE, 3'b001, 6'd4, 32'h102, 32'h0000BEEF);
        tests_run++; if (dcache_req_wdata !== 32'hBEEFBEEF || dcache_req_wmask !== 4'b1100) begin
            tests_failed++; $display("FAIL sh_lanes: d=%h m=%b want beefbeef/1100", dcache_req_wdata, dcache_req_wmask); end
        tick();
        tests_run++; if (cdb_out.is_valid !== 1'b1 || cdb_out.dest_tag !== 6'd4) begin
            tests_failed++; $display("FAIL sh_latency: valid=%b tag=%0d want 1/4", cdb_out.is_valid, cdb_out.dest_tag); end
        grant_cycle();
    endtask

    task automatic test_flush_wait();
        dcache_req_rdy = 1'b1;
        drive_op(OPC_LOAD, 3'b010, 6'd9, 32'h200, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        tests_run++; if (dbg_state !== 2'd0 || alu_rdy !== 1'b0 || cache_stall !== 1'b0) begin
            tests_failed++; $display("FAIL flush_wait_idle: state=%0d rdy=%b stall=%b want 0/0/0", dbg_state, alu_rdy, cache_stall); end
        tick();
        tests_run++; if (alu_rdy !== 1'b0) begin tests_failed++; $display("FAIL flush_wait_draining: rdy=%b want 0", alu_rdy); end
        dcache_resp_valid = 1'b1;
        dcache_resp_data  = 32'h55555555;
        tick();
        dcache_resp_valid = 1'b0;
        tests_run++; if (cdb_out.is_valid !== 1'b0 || alu_rdy !== 1'b1) begin
            tests_failed++; $display("FAIL flush_wait_drained: cdb_valid=%b rdy=%b want 0/1", cdb_out.is_valid, alu_rdy); end
    endtask

    task automatic test_flush_req_and_wb();
        dcache_req_rdy = 1'b1;
        drive_op(OPC_LOAD, 3'b010, 6'd10, 32'h300, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        tests_run++; if (alu_rdy !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++; $display("FAIL flush_req_accepted: rdy=%b state=%0d want 0/0", alu_rdy, dbg_state); end
        dcache_resp_valid = 1'b1;
        tick();
        dcache_resp_valid = 1'b0;
        tests_run++; if (alu_rdy !== 1'b1 || cdb_out.is_valid !== 1'b0) begin
            tests_failed++; $display("FAIL flush_req_drained: rdy=%b cdb_valid=%b want 1/0", alu_rdy, cdb_out.is_valid); end
        // Store in WB: flush together with grant resolves as a single flush.
        drive_op(OPC_STORE, 3'b010, 6'd11, 32'h304, 32'h01020304);
        tick();
        flush = 1'b1;
        cdb_grant = 1'b1;
        tick();
        flush = 1'b0;
        cdb_grant = 1'b0;
        #1;
        tests_run++; if (cdb_out !== '0 || alu_rdy !== 1'b1 || dbg_state !== 2'd0) begin
            tests_failed++; $display("FAIL flush_wb_grant: cdb=%h rdy=%b state=%0d want 0/1/0", cdb_out, alu_rdy, dbg_state); end
    endtask

    task automatic test_misalign();
        dcache_req_rdy = 1'b1;
        drive_op(OPC_LOAD, 3'b010, 6'd5, 32'h102, 32'h0);
`ifdef MEM_MISALIGN_EXC_EN
        tests_run++; if (dcache_req_valid !== 1'b0 || cdb_out !== '{1'b1, 6'd5, 32'h0, 1'b1}) begin
            tests_failed++; $display("FAIL misalign_exc: req_v=%b cdb=%h want 0/exc tag5", dcache_req_valid, cdb_out); end
`else
        tests_run++; if (dcache_req_valid !== 1'b1 || dcache_req_addr !== 32'h100) begin
            tests_failed++; $display("FAIL misalign_req: v=%b a=%h want 1/00000100", dcache_req_valid, dcache_req_addr); end
        tick();
        dcache_resp_valid = 1'b1;
        dcache_resp_data  = 32'h11223344;
        tick();
        dcache_resp_valid = 1'b0;
        tests_run++; if (cdb_out.result !== 32'h11223344 || cdb_out.exception !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_result: result=%h exc=%b want 11223344/0", cdb_out.result, cdb_out.exception); end
`endif
        grant_cycle();
    endtask

    task automatic test_rst_midop();
        dcache_req_rdy = 1'b0;
        drive_op(OPC_LOAD, 3'b010, 6'd12, 32'h400, 32'h0);
        tests_run++; if (dcache_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_req: v=%b want 1", dcache_req_valid); end
        #1 rst = 1'b0;
        #1;
        tests_run++; if (dcache_req_valid !== 1'b0 || cache_stall !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async_drop: v=%b stall=%b want 0/0", dcache_req_valid, cache_stall); end
        @(negedge clk) rst = 1'b1;
        tick();
        tests_run++; if (alu_rdy !== 1'b1 || dbg_state !== 2'd0) begin
            tests_failed++; $display("FAIL rst_release: rdy=%b state=%0d want 1/0", alu_rdy, dbg_state); end
        dcache_req_rdy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store_stall();
        test_flush_wait();
        test_flush_req_and_wb();
        test_misalign();
        test_rst_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_exec_unit.md
Name: mem_exec_unit

Overview:
Memory execution stage downstream of the LSQ, and the consumer end of the LSQ's execute_pkt/alu_rdy handshake. It accepts one resolved load or store at a time and issues it to the data cache request/response port. It aligns and extends load data, then returns a writeback_packet_t on its CDB port under grant. It asserts cache_stall back to the LSQ while it is occupied.

Parameters:
ADDR_BITS, 32, byte-address width presented to the data cache.
DRAIN_MAX, 15, saturation limit of the count of responses owed after a flush.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low (resets while rst==0)
flush  input  1  pipeline flush; drops in-flight op
execute_pkt  input  instruction_t  op from LSQ; valid when execute_pkt.is_valid
alu_rdy  output  1  ready to accept execute_pkt this cycle
cache_stall  output  1  high whenever FSM != IDLE
dcache_req_valid  output  1  cache request valid
dcache_req_rdy  input  1  cache accepts request
dcache_req_we  output  1  1=store, 0=load
dcache_req_addr  output  ADDR_BITS  word-aligned address ({addr[ADDR_BITS-1:2],2'b00})
dcache_req_wdata  output  CPU_DATA_BITS  store data, lane-shifted
dcache_req_wmask  output  4  byte enables
dcache_resp_valid  input  1  load response valid (stores get no response)
dcache_resp_data  input  CPU_DATA_BITS  response word
cdb_out  output  writeback_packet_t  result to CDB
cdb_grant  input  1  CDB accepted cdb_out this cycle

Behaviour:
- Field usage: effective address = src_0_a.data; store data = src_1_a.data; size/sign = funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU); opcode STORE selects store.
- Reset (rst==0) sets FSM=IDLE, alu_rdy=1, cache_stall=0, dcache_req_valid=0, dcache_req_we=0, addr/wdata/wmask=0, cdb_out='0, drain count=0.
- Handshake: transfer occurs when alu_rdy && execute_pkt.is_valid. alu_rdy = (FSM==IDLE) && drain count==0 && !flush.
- State IDLE: on transfer, latch op. A misaligned op (H with addr[0]=1; W with addr[1:0]!=0) goes to WB with exception=1 and issues no cache request. Any other op goes to REQ.
- State REQ: dcache_req_valid=1, and all request fields stay stable until dcache_req_rdy. On accept, a store goes to WB and a load goes to WAIT.
- Store wdata/wmask: B uses data[7:0] replicated in all lanes, mask = 1<<addr[1:0]. H uses data[15:0] in both halves, mask = 0011<<addr[1:0]. W uses mask 1111.
- State WAIT: on dcache_resp_valid, select the byte/half at addr[1:0], zero- or sign-extend per funct3 into result, then go to WB.
- State WB: cdb_out.is_valid=1, dest_tag=latched tag. Result is the load value, or 0 for a store. exception is set for misalignment only. Hold until cdb_grant, then go to IDLE and clear cdb_out.
- Minimum load latency: transfer at T, request at T+1 (rdy=1), response at T+2, cdb_out valid at T+3. A store with rdy=1 at T+1 has cdb_out valid at T+2.
- Flush, by state:
  - In IDLE or WB, the op is dropped; cdb_out is cleared next cycle; FSM goes to IDLE.
  - In REQ, an unaccepted request is withdrawn and FSM goes to IDLE. If dcache_req_rdy is high in the flush cycle, the request counts as accepted, and a load increments the drain count.
  - In WAIT, the drain count increments and FSM goes to IDLE.
  - A transfer presented in a flush cycle is ignored.
- Drain: each dcache_resp_valid while drain count>0 decrements the count and is discarded. alu_rdy stays low until the count reaches 0. The count saturates at DRAIN_MAX.
- Simultaneous events: cdb_grant and flush in the same cycle resolve as flush (no double count); the CDB is expected to discard. Response and flush in WAIT in the same cycle drop the response; drain count stays 0.
- rst asserted mid-operation returns all state to reset values immediately (asynchronous).

Optional Feature:
MEM_MISALIGN_EXC_EN:
- Defined: misaligned ops raise exception=1 as above and issue no cache access.
- Undefined: no misalign check; low address bits are ignored for H/W (H forced to addr[1]*2, W to offset 0) and the op proceeds normally; exception is always 0.

Test Plan:
- LW, addr 0x100, tag 8, rdy=1, response 0xDEADBEEF next cycle -> cdb_out {valid, tag 8, result 0xDEADBEEF, exc 0} at T+3, held until cdb_grant.
- LB, addr 0x103, response 0x80FF0000 -> result 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB, addr 0x101, data 0xAB, dcache_req_rdy low 3 cycles -> req held stable with wdata 0xABABABAB, wmask 0010, addr 0x100; WB result 0 after accept.
- Flush in WAIT -> FSM IDLE, alu_rdy low until the late response arrives, response dropped (no cdb_out), alu_rdy high the cycle after.
- LW, addr 0x102 with MEM_MISALIGN_EXC_EN -> no dcache_req_valid; cdb_out exc=1 at T+1. Without the macro -> request to 0x100.
- cache_stall high from T+1 to grant; rst pulsed low in REQ -> dcache_req_valid drops immediately and alu_rdy=1 after release.
